// File: rtl/blocking_port_arbiter.sv
// Round-robin arbiter sharing one blocking output port among N blocking inputs.
// One word per grant: ARB picks a winner, READ takes its word, WRITE offers it.
module blocking_port_arbiter #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_sync,
    output logic [N-1:0]         in_notify,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    input  logic                 out_sync,
    output logic                 out_notify
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    localparam logic [1:0] ARB   = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] pick;
    logic          found;

    // Scan from ptr upward with wrap; the first pending requester wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            logic [PW-1:0] pj;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            pj = PW'(j);
            if (!found && in_sync[pj]) begin
                found = 1'b1;
                pick  = pj;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            ptr        <= '0;
            winner     <= '0;
            in_notify  <= '0;
            out_notify <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (found) begin
                        winner    <= pick;
                        in_notify <= N'(1) << pick;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (in_sync[winner]) begin
                        out_data   <= in_data[winner*W +: W];
                        out_src    <= winner;
                        in_notify  <= '0;
                        out_notify <= 1'b1;
                        ptr        <= (winner == LAST) ? '0 : winner + 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (out_sync) begin
                        out_notify <= 1'b0;
                        state      <= ARB;
                    end
                end
                default: begin
                    in_notify  <= '0;
                    out_notify <= 1'b0;
                    state      <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blocking_port_arbiter.sv
// Directed bench for blocking_port_arbiter (N=4, W=32).
// Linear step sequence with immediate-assertion checks.
module tb_blocking_port_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_sync;
    logic [N-1:0]   in_notify;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_sync;
    logic           out_notify;

    int tests;
    int fails;

    blocking_port_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sync    (in_sync),
        .in_notify  (in_notify),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_sync   (out_sync),
        .out_notify (out_notify)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] src,
                             input logic [31:0] dat);
        check({tag, ".on"}, 64'(out_notify), 64'd1);
        check({tag, ".src"}, 64'(out_src), 64'(src));
        check({tag, ".data"}, 64'(out_data), 64'(dat));
        check({tag, ".in_n"}, 64'(in_notify), 64'd0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_sync  = '0;
        out_sync = 1'b0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i + 100);
        #3;
        check("rst.in_n", 64'(in_notify), 64'd0);
        check("rst.on", 64'(out_notify), 64'd0);
        check("rst.data", 64'(out_data), 64'd0);
        check("rst.src", 64'(out_src), 64'd0);
        tick();
        rst = 1'b0;

        // single requester 2
        in_data[2*W +: W] = 32'hA5A5_0001;
        in_sync = 4'b0100;
        out_sync = 1'b1;
        tick();
        check("t1.in_n", 64'(in_notify), 64'b0100);
        check("t1.on0", 64'(out_notify), 64'd0);
        tick();
        in_sync = 4'b0000;
        check_out("t1.w", 2'd2, 32'hA5A5_0001);
        tick();
        check("t1.done", 64'(out_notify), 64'd0);

        // wrap-around: ptr is 3 now
        in_sync = 4'b1001;
        tick();
        check("wr.g3", 64'(in_notify), 64'b1000);
        tick();
        in_sync = 4'b0001;
        check_out("wr.w3", 2'd3, 32'd103);
        tick();
        tick();
        check("wr.g0", 64'(in_notify), 64'b0001);
        tick();
        in_sync = 4'b0000;
        check_out("wr.w0", 2'd0, 32'd100);
        tick();

        // all requesting continuously from ptr 0
        rst = 1'b1;
        #2;
        rst = 1'b0;
        in_data[2*W +: W] = 32'd102;
        in_sync = 4'b1111;
        out_sync = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("rr.grant", 64'(in_notify), 64'(4'b0001 << (n % 4)));
            tick();
            check_out("rr.w", 2'(n % 4), 32'(100 + n % 4));
            tick();
            check("rr.arb", 64'(out_notify), 64'd0);
        end

        // consumer stall on the word from 1
        out_sync = 1'b0;
        tick();
        check("cs.g1", 64'(in_notify), 64'b0010);
        tick();
        check_out("cs.w", 2'd1, 32'd101);
        in_data[1*W +: W] = 32'd999;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_out("cs.hold", 2'd1, 32'd101);
        end
        in_data[1*W +: W] = 32'd101;
        out_sync = 1'b1;
        tick();
        check("cs.rel", 64'(out_notify), 64'd0);
        tick();
        check("cs.g2", 64'(in_notify), 64'b0100);
        tick();
        check_out("cs.w2", 2'd2, 32'd102);
        tick();

        // reset mid-WRITE (ptr is 3)
        in_sync = 4'b0001;
        out_sync = 1'b0;
        tick();
        check("rw.g0", 64'(in_notify), 64'b0001);
        tick();
        check_out("rw.w", 2'd0, 32'd100);
        #2;
        rst = 1'b1;
        #1;
        check("rw.on", 64'(out_notify), 64'd0);
        check("rw.in_n", 64'(in_notify), 64'd0);
        check("rw.data", 64'(out_data), 64'd0);
        check("rw.src", 64'(out_src), 64'd0);
        #1;
        rst = 1'b0;

        // producer stall: winner 1 drops sync, 3 waits
        in_sync = 4'b1010;
        out_sync = 1'b1;
        tick();
        check("ps.g1", 64'(in_notify), 64'b0010);
        in_sync = 4'b1000;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("ps.hold", 64'(in_notify), 64'b0010);
            check("ps.on", 64'(out_notify), 64'd0);
        end
        in_sync = 4'b1010;
        tick();
        in_sync = 4'b1000;
        check_out("ps.w1", 2'd1, 32'd101);
        tick();
        check("ps.arb", 64'(out_notify), 64'd0);
        tick();
        check("ps.g3", 64'(in_notify), 64'b1000);
        tick();
        in_sync = 4'b0000;
        check_out("ps.w3", 2'd3, 32'd103);
        tick();
        check("ps.end", 64'(out_notify), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
